// File: rtl/dca_matrix_walk_controller.sv
// DCA matrix walk controller: walks a 2-D matrix region and emits one element
// address per accepted request beat, with inner-dimension and end-of-walk flags.
// Optional multi-pass walking is enabled by defining DCA_MATRIX_WALK_REPEAT_EN.
module dca_matrix_walk_controller #(
  parameter int unsigned BW_ADDR    = 32,
  parameter int unsigned BW_NUM_ROW = 8,
  parameter int unsigned BW_NUM_COL = 8,
  parameter int unsigned BW_STRIDE  = 16
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  cfg_is_col_first,
  input  logic [BW_ADDR-1:0]    cfg_base_addr,
  input  logic [BW_STRIDE-1:0]  cfg_row_stride,
  input  logic [BW_STRIDE-1:0]  cfg_elem_stride,
  input  logic [BW_NUM_ROW-1:0] cfg_num_row_m1,
  input  logic [BW_NUM_COL-1:0] cfg_num_col_m1,
`ifdef DCA_MATRIX_WALK_REPEAT_EN
  input  logic [7:0]            cfg_num_repeat_m1,
  output logic                  req_last_pass,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [BW_ADDR-1:0]    req_addr,
  output logic [BW_NUM_ROW-1:0] req_row,
  output logic [BW_NUM_COL-1:0] req_col,
  output logic                  req_first_x,
  output logic                  req_last_x,
  output logic                  req_last
);

  localparam int unsigned BW_REPEAT = 8;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state_q;
  logic                    col_first_q;
  logic [BW_ADDR-1:0]      base_q;
  logic [BW_ADDR-1:0]      line_q;
  logic [BW_STRIDE-1:0]    row_stride_q;
  logic [BW_STRIDE-1:0]    elem_stride_q;
  logic [BW_NUM_ROW-1:0]   num_row_m1_q;
  logic [BW_NUM_COL-1:0]   num_col_m1_q;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
  logic [BW_REPEAT-1:0]    num_repeat_m1_q;
  logic [BW_REPEAT-1:0]    pass_q;
  logic [BW_REPEAT-1:0]    pass_d;
`endif

  logic                    xfer_c;
  logic                    end_pos_c;
  logic [BW_NUM_ROW-1:0]   row_d;
  logic [BW_NUM_COL-1:0]   col_d;
  logic [BW_ADDR-1:0]      addr_d;
  logic [BW_ADDR-1:0]      line_d;
  logic                    first_x_d;
  logic                    last_x_d;
  logic                    end_pos_d;

  assign xfer_c    = req_valid & req_ready;
  assign end_pos_c = (req_row == num_row_m1_q) && (req_col == num_col_m1_q);
`ifdef DCA_MATRIX_WALK_REPEAT_EN
  assign pass_d    = BW_REPEAT'(pass_q + BW_REPEAT'(1));
`endif

  // Next position in the walk: step the inner index, or wrap it and start a new outer line.
  always_comb begin
    row_d  = req_row;
    col_d  = req_col;
    addr_d = req_addr;
    line_d = line_q;
    if (col_first_q) begin
      if (req_col == num_col_m1_q) begin
        col_d  = '0;
        row_d  = BW_NUM_ROW'(req_row + BW_NUM_ROW'(1));
        addr_d = BW_ADDR'(line_q + BW_ADDR'(row_stride_q));
        line_d = BW_ADDR'(line_q + BW_ADDR'(row_stride_q));
      end else begin
        col_d  = BW_NUM_COL'(req_col + BW_NUM_COL'(1));
        addr_d = BW_ADDR'(req_addr + BW_ADDR'(elem_stride_q));
      end
    end else begin
      if (req_row == num_row_m1_q) begin
        row_d  = '0;
        col_d  = BW_NUM_COL'(req_col + BW_NUM_COL'(1));
        addr_d = BW_ADDR'(line_q + BW_ADDR'(elem_stride_q));
        line_d = BW_ADDR'(line_q + BW_ADDR'(elem_stride_q));
      end else begin
        row_d  = BW_NUM_ROW'(req_row + BW_NUM_ROW'(1));
        addr_d = BW_ADDR'(req_addr + BW_ADDR'(row_stride_q));
      end
    end
  end

  // Position flags belonging to the next position.
  always_comb begin
    first_x_d = col_first_q ? (col_d == '0) : (row_d == '0);
    last_x_d  = col_first_q ? (col_d == num_col_m1_q) : (row_d == num_row_m1_q);
    end_pos_d = (row_d == num_row_m1_q) && (col_d == num_col_m1_q);
  end

  // Command FSM, latched configuration and registered request stream.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      col_first_q   <= 1'b0;
      base_q        <= '0;
      line_q        <= '0;
      row_stride_q  <= '0;
      elem_stride_q <= '0;
      num_row_m1_q  <= '0;
      num_col_m1_q  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_row       <= '0;
      req_col       <= '0;
      req_first_x   <= 1'b0;
      req_last_x    <= 1'b0;
      req_last      <= 1'b0;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
      num_repeat_m1_q <= '0;
      pass_q          <= '0;
      req_last_pass   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (clear) begin
        state_q     <= ST_IDLE;
        busy        <= 1'b0;
        req_valid   <= 1'b0;
        req_addr    <= '0;
        req_row     <= '0;
        req_col     <= '0;
        req_first_x <= 1'b0;
        req_last_x  <= 1'b0;
        req_last    <= 1'b0;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
        req_last_pass <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q       <= ST_RUN;
              col_first_q   <= cfg_is_col_first;
              base_q        <= cfg_base_addr;
              line_q        <= cfg_base_addr;
              row_stride_q  <= cfg_row_stride;
              elem_stride_q <= cfg_elem_stride;
              num_row_m1_q  <= cfg_num_row_m1;
              num_col_m1_q  <= cfg_num_col_m1;
              busy          <= 1'b1;
              req_valid     <= 1'b1;
              req_addr      <= cfg_base_addr;
              req_row       <= '0;
              req_col       <= '0;
              req_first_x   <= 1'b1;
              req_last_x    <= cfg_is_col_first ? (cfg_num_col_m1 == '0) : (cfg_num_row_m1 == '0);
`ifdef DCA_MATRIX_WALK_REPEAT_EN
              num_repeat_m1_q <= cfg_num_repeat_m1;
              pass_q          <= '0;
              req_last_pass   <= (cfg_num_repeat_m1 == '0);
              req_last        <= (cfg_num_row_m1 == '0) && (cfg_num_col_m1 == '0) &&
                                 (cfg_num_repeat_m1 == '0);
`else
              req_last        <= (cfg_num_row_m1 == '0) && (cfg_num_col_m1 == '0);
`endif
            end
          end
          ST_RUN: begin
            if (xfer_c) begin
              if (req_last) begin
                state_q     <= ST_IDLE;
                busy        <= 1'b0;
                done        <= 1'b1;
                req_valid   <= 1'b0;
                req_addr    <= '0;
                req_row     <= '0;
                req_col     <= '0;
                req_first_x <= 1'b0;
                req_last_x  <= 1'b0;
                req_last    <= 1'b0;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
                req_last_pass <= 1'b0;
              end else if (end_pos_c) begin
                // End of a non-final pass: restart at base with no bubble.
                pass_q        <= pass_d;
                req_last_pass <= (pass_d == num_repeat_m1_q);
                line_q        <= base_q;
                req_addr      <= base_q;
                req_row       <= '0;
                req_col       <= '0;
                req_first_x   <= 1'b1;
                req_last_x    <= col_first_q ? (num_col_m1_q == '0) : (num_row_m1_q == '0);
                req_last      <= (num_row_m1_q == '0) && (num_col_m1_q == '0) &&
                                 (pass_d == num_repeat_m1_q);
`endif
              end else begin
                line_q      <= line_d;
                req_addr    <= addr_d;
                req_row     <= row_d;
                req_col     <= col_d;
                req_first_x <= first_x_d;
                req_last_x  <= last_x_d;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
                req_last    <= end_pos_d & req_last_pass;
`else
                req_last    <= end_pos_d;
`endif
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dca_matrix_walk_controller.sv
// Self-checking bench for dca_matrix_walk_controller: directed walks from the
// test plan plus randomized walks with random backpressure, checked against a
// queue of expected beats built from nested loops over the matrix.
module tb_dca_matrix_walk_controller;

  logic        clk;
  logic        rstnn;
  logic        clear;
  logic        start;
  logic        cfg_is_col_first;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_row_stride;
  logic [15:0] cfg_elem_stride;
  logic [7:0]  cfg_num_row_m1;
  logic [7:0]  cfg_num_col_m1;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
  logic [7:0]  cfg_num_repeat_m1;
  logic        req_last_pass;
`endif
  logic        busy;
  logic        done;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_row;
  logic [7:0]  req_col;
  logic        req_first_x;
  logic        req_last_x;
  logic        req_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        fx;
    logic        lx;
    logic        l;
    logic        lp;
  } beat_t;

  beat_t exp_q[$];

  dca_matrix_walk_controller dut (
    .clk              (clk),
    .rstnn            (rstnn),
    .clear            (clear),
    .start            (start),
    .cfg_is_col_first (cfg_is_col_first),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_row_stride   (cfg_row_stride),
    .cfg_elem_stride  (cfg_elem_stride),
    .cfg_num_row_m1   (cfg_num_row_m1),
    .cfg_num_col_m1   (cfg_num_col_m1),
`ifdef DCA_MATRIX_WALK_REPEAT_EN
    .cfg_num_repeat_m1(cfg_num_repeat_m1),
    .req_last_pass    (req_last_pass),
`endif
    .busy             (busy),
    .done             (done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_row          (req_row),
    .req_col          (req_col),
    .req_first_x      (req_first_x),
    .req_last_x       (req_last_x),
    .req_last         (req_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive garbage onto the configuration inputs; a walk in flight must ignore it.
  task automatic scramble_cfg();
    cfg_is_col_first = 1'($urandom);
    cfg_base_addr    = $urandom;
    cfg_row_stride   = 16'($urandom);
    cfg_elem_stride  = 16'($urandom);
    cfg_num_row_m1   = 8'($urandom);
    cfg_num_col_m1   = 8'($urandom);
`ifdef DCA_MATRIX_WALK_REPEAT_EN
    cfg_num_repeat_m1 = 8'($urandom);
`endif
  endtask

  // Start a walk (call at posedge+1) and build its expected beat list.
  task automatic issue(input logic cf, input logic [31:0] base, input logic [15:0] rs,
                       input logic [15:0] es, input int nr, input int nc, input int rep);
    int inner_n, outer_n;
    beat_t b;
    cfg_is_col_first = cf;
    cfg_base_addr    = base;
    cfg_row_stride   = rs;
    cfg_elem_stride  = es;
    cfg_num_row_m1   = 8'(nr);
    cfg_num_col_m1   = 8'(nc);
`ifdef DCA_MATRIX_WALK_REPEAT_EN
    cfg_num_repeat_m1 = 8'(rep);
`endif
    start = 1'b1;
    exp_q.delete();
    inner_n = cf ? nc + 1 : nr + 1;
    outer_n = cf ? nr + 1 : nc + 1;
    for (int p = 0; p <= rep; p++)
      for (int o = 0; o < outer_n; o++)
        for (int i = 0; i < inner_n; i++) begin
          b.row  = 8'(cf ? o : i);
          b.col  = 8'(cf ? i : o);
          b.addr = base + 32'(b.row) * 32'(rs) + 32'(b.col) * 32'(es);
          b.fx   = (i == 0);
          b.lx   = (i == inner_n - 1);
          b.l    = (p == rep) && (o == outer_n - 1) && (i == inner_n - 1);
          b.lp   = (p == rep);
          exp_q.push_back(b);
        end
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
  endtask

  // Consume beats; mode 0: ready always, 1: random, 2: pattern 1,0,0.
  // max_beats < 0 consumes the whole walk and then checks the done cycle.
  task automatic consume(input int mode, input int max_beats);
    int k = 0;
    int taken = 0;
    beat_t b;
    while (exp_q.size() > 0 && (max_beats < 0 || taken < max_beats)) begin
      if (k > 2000) begin
        check_eq("walk_timeout", 64'(k), 64'(0));
        break;
      end
      case (mode)
        0:       req_ready = 1'b1;
        1:       req_ready = 1'($urandom);
        default: req_ready = (k % 3 == 0);
      endcase
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      b = exp_q[0];
      check_eq("busy",    64'(busy),        64'(1));
      check_eq("valid",   64'(req_valid),   64'(1));
      check_eq("addr",    64'(req_addr),    64'(b.addr));
      check_eq("row",     64'(req_row),     64'(b.row));
      check_eq("col",     64'(req_col),     64'(b.col));
      check_eq("first_x", 64'(req_first_x), 64'(b.fx));
      check_eq("last_x",  64'(req_last_x),  64'(b.lx));
      check_eq("last",    64'(req_last),    64'(b.l));
      check_eq("done_mid",64'(done),        64'(0));
`ifdef DCA_MATRIX_WALK_REPEAT_EN
      check_eq("last_pass", 64'(req_last_pass), 64'(b.lp));
`endif
      if (req_ready) begin
        void'(exp_q.pop_front());
        taken++;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    req_ready = 1'b0;
    if (max_beats < 0) begin
      check_eq("done_pulse", 64'(done),      64'(1));
      check_eq("done_busy",  64'(busy),      64'(0));
      check_eq("done_valid", 64'(req_valid), 64'(0));
    end
  endtask

  // One idle cycle after the done cycle: pulse must have ended.
  task automatic idle_check();
    @(posedge clk); #1;
    check_eq("idle_done",  64'(done),      64'(0));
    check_eq("idle_busy",  64'(busy),      64'(0));
    check_eq("idle_valid", 64'(req_valid), 64'(0));
  endtask

  initial begin
    rstnn     = 1'b0;
    clear     = 1'b0;
    start     = 1'b0;
    req_ready = 1'b0;
    scramble_cfg();
    #12;
    check_eq("rst_busy",  64'(busy),        64'(0));
    check_eq("rst_done",  64'(done),        64'(0));
    check_eq("rst_valid", 64'(req_valid),   64'(0));
    check_eq("rst_addr",  64'(req_addr),    64'(0));
    check_eq("rst_row",   64'(req_row),     64'(0));
    check_eq("rst_col",   64'(req_col),     64'(0));
    check_eq("rst_flags", 64'({req_first_x, req_last_x, req_last}), 64'(0));
    @(posedge clk); #1;
    rstnn = 1'b1;
    @(posedge clk); #1;

    // Row-major 2x3, full throughput
    issue(1'b1, 32'h1000, 16'h40, 16'h4, 1, 2, 0);
    consume(0, -1);
    idle_check();

    // Column-major, same region
    issue(1'b0, 32'h1000, 16'h40, 16'h4, 1, 2, 0);
    consume(0, -1);
    idle_check();

    // Backpressure pattern
    issue(1'b1, 32'h1000, 16'h40, 16'h4, 1, 2, 0);
    consume(2, -1);
    idle_check();

    // Clear after two beats, clear wins over a simultaneous transfer
    issue(1'b1, 32'h1000, 16'h40, 16'h4, 1, 2, 0);
    consume(0, 2);
    clear     = 1'b1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    clear     = 1'b0;
    req_ready = 1'b0;
    check_eq("clr_busy",  64'(busy),      64'(0));
    check_eq("clr_valid", 64'(req_valid), 64'(0));
    check_eq("clr_done",  64'(done),      64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("clr_no_done", 64'(done), 64'(0));
    end
    issue(1'b1, 32'h1000, 16'h40, 16'h4, 1, 2, 0);
    consume(1, -1);
    idle_check();

    // 1x1 at top of address space, then back-to-back start in the done cycle
    issue(1'b1, 32'hFFFF_FFFC, 16'h40, 16'h4, 0, 0, 0);
    consume(0, -1);
    issue(1'b0, 32'h2000, 16'h100, 16'h8, 1, 2, 0);
    consume(1, -1);
    idle_check();

`ifdef DCA_MATRIX_WALK_REPEAT_EN
    // Two passes over 1x2, no bubble between passes
    issue(1'b1, 32'h3000, 16'h40, 16'h4, 0, 1, 1);
    consume(0, -1);
    idle_check();
`endif

    // Randomized walks, including address wrap and back-to-back starts
    for (int t = 0; t < 30; t++) begin
      int rep;
      rep = 0;
`ifdef DCA_MATRIX_WALK_REPEAT_EN
      rep = $urandom_range(0, 2);
`endif
      issue(1'($urandom), $urandom, 16'($urandom), 16'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 4), rep);
      consume($urandom_range(0, 2), -1);
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
